// File: rtl/i8088_bus_target_if.sv
// ---------------------------------------------------------------------------
// i8088_bus_target_if
// Bundles the 8088 local-bus signals and the simple back-end request/response
// port used by i8088_bus_target.
//   CPU side : ALE, RD_n, WR_n, IOM, INTA_n, addr, dout (to target),
//              din, READY (from target)
//   Back-end : req_valid, req_write, req_io, req_inta, req_addr, req_wdata,
//              timeout (from target); req_ready, rsp_valid, rsp_rdata (to target)
// Modports:
//   slave  - the bus target itself
//   master - the environment (CPU wrapper plus memory/IO fabric)
// ---------------------------------------------------------------------------
interface i8088_bus_target_if;
    // CPU local bus
    logic        ALE;
    logic        RD_n;
    logic        WR_n;
    logic        IOM;
    logic        INTA_n;
    logic [19:0] addr;
    logic [7:0]  dout;
    logic [7:0]  din;
    logic        READY;
    // Back-end request/response port
    logic        req_valid;
    logic        req_write;
    logic        req_io;
    logic        req_inta;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        timeout;

    modport slave (
        input  ALE, RD_n, WR_n, IOM, INTA_n, addr, dout,
        input  req_ready, rsp_valid, rsp_rdata,
        output din, READY,
        output req_valid, req_write, req_io, req_inta, req_addr, req_wdata,
        output timeout
    );

    modport master (
        output ALE, RD_n, WR_n, IOM, INTA_n, addr, dout,
        output req_ready, rsp_valid, rsp_rdata,
        input  din, READY,
        input  req_valid, req_write, req_io, req_inta, req_addr, req_wdata,
        input  timeout
    );
endinterface

// File: rtl/i8088_bus_target.sv
// ---------------------------------------------------------------------------
// i8088_bus_target
// Turns each 8088 local-bus cycle into a single valid/ready request on a
// simple back-end port. READY is held low from the ALE falling edge until
// the back-end completes (plus MIN_WAIT extra cycles), read data is returned
// on din. Interrupt-acknowledge pairs are handled here: the first INTA
// strobe is answered locally, the second becomes a vector-fetch request.
// A request that does not complete within TIMEOUT cycles is aborted, reads
// then return OPEN_BUS and a one-cycle timeout pulse is issued.
//
// Ports:
//   CORE_CLK  - sole clock
//   RESET     - synchronous, active-high reset
//   bus       - i8088_bus_target_if.slave (CPU bus + back-end port)
// All outputs are registered.
// ---------------------------------------------------------------------------
module i8088_bus_target #(
    parameter int unsigned MIN_WAIT = 0,
    parameter int unsigned TIMEOUT  = 1023,
    parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
    input  logic              CORE_CLK,
    input  logic              RESET,
    i8088_bus_target_if.slave bus
);

    // Timeout counter is at least 10 bits, wider if TIMEOUT needs it.
    localparam int unsigned TO_W =
        ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STROBE,
        ST_REQ,
        ST_RSP,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t            state_reg;
    logic              ale_prev_reg;
    logic              inta_phase_reg;
    logic [3:0]        wait_cnt_reg;
    logic [TO_W-1:0]   to_cnt_reg;

    logic [7:0]        din_reg;
    logic              ready_reg;
    logic              req_valid_reg;
    logic              req_write_reg;
    logic              req_io_reg;
    logic              req_inta_reg;
    logic [19:0]       req_addr_reg;
    logic [7:0]        req_wdata_reg;
    logic              timeout_reg;

    logic [TO_W-1:0]   to_cnt_inc;
    logic              expire;

    // The counter is cleared on REQ entry, so the TIMEOUT-th edge spent in
    // REQ/RSP is the one where the incremented value equals TIMEOUT.
    assign to_cnt_inc = to_cnt_reg + TO_W'(1);
    assign expire     = (TIMEOUT != 0) && (to_cnt_inc == TO_W'(TIMEOUT));

    always_ff @(posedge CORE_CLK) begin
        if (RESET) begin
            state_reg      <= ST_IDLE;
            ale_prev_reg   <= 1'b0;
            inta_phase_reg <= 1'b0;
            wait_cnt_reg   <= '0;
            to_cnt_reg     <= '0;
            din_reg        <= 8'h00;
            ready_reg      <= 1'b1;
            req_valid_reg  <= 1'b0;
            req_write_reg  <= 1'b0;
            req_io_reg     <= 1'b0;
            req_inta_reg   <= 1'b0;
            req_addr_reg   <= '0;
            req_wdata_reg  <= '0;
            timeout_reg    <= 1'b0;
        end else begin
            ale_prev_reg <= bus.ALE;
            timeout_reg  <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (bus.ALE) begin
                        req_addr_reg <= bus.addr;
                    end else if (ale_prev_reg) begin
                        // ALE fell: a bus cycle has begun, stall the CPU now.
                        state_reg <= ST_STROBE;
                        ready_reg <= 1'b0;
                    end
                end

                ST_STROBE: begin
                    if (!bus.WR_n) begin
                        req_wdata_reg  <= bus.dout;
                        req_write_reg  <= 1'b1;
                        req_io_reg     <= bus.IOM;
                        req_inta_reg   <= 1'b0;
                        inta_phase_reg <= 1'b0;
                        req_valid_reg  <= 1'b1;
                        to_cnt_reg     <= '0;
                        state_reg      <= ST_REQ;
                    end else if (!bus.RD_n) begin
                        req_write_reg  <= 1'b0;
                        req_io_reg     <= bus.IOM;
                        req_inta_reg   <= 1'b0;
                        inta_phase_reg <= 1'b0;
                        req_valid_reg  <= 1'b1;
                        to_cnt_reg     <= '0;
                        state_reg      <= ST_REQ;
                    end else if (!bus.INTA_n) begin
                        inta_phase_reg <= ~inta_phase_reg;
                        if (inta_phase_reg) begin
                            // Second INTA of the pair fetches the vector.
                            req_inta_reg  <= 1'b1;
                            req_write_reg <= 1'b0;
                            req_io_reg    <= 1'b0;
                            req_valid_reg <= 1'b1;
                            to_cnt_reg    <= '0;
                            state_reg     <= ST_REQ;
                        end else begin
                            // First INTA carries no data; release the CPU.
                            ready_reg <= 1'b1;
                            state_reg <= ST_DONE;
                        end
                    end else if (bus.ALE) begin
                        // New ALE without a strobe (e.g. halt cycle).
                        req_addr_reg <= bus.addr;
                        ready_reg    <= 1'b1;
                        state_reg    <= ST_IDLE;
                    end
                end

                ST_REQ: begin
                    if (bus.req_ready) begin
                        // Handshake beats a simultaneous expiry.
                        req_valid_reg <= 1'b0;
                        wait_cnt_reg  <= '0;
                        to_cnt_reg    <= to_cnt_inc;
                        state_reg     <= req_write_reg ? ST_HOLD : ST_RSP;
                    end else if (expire) begin
                        req_valid_reg <= 1'b0;
                        if (!req_write_reg) begin
                            din_reg <= OPEN_BUS;
                        end
                        timeout_reg <= 1'b1;
                        ready_reg   <= 1'b1;
                        state_reg   <= ST_DONE;
                    end else begin
                        to_cnt_reg <= to_cnt_inc;
                    end
                end

                ST_RSP: begin
                    if (bus.rsp_valid) begin
                        din_reg      <= bus.rsp_rdata;
                        wait_cnt_reg <= '0;
                        state_reg    <= ST_HOLD;
                    end else if (expire) begin
                        din_reg     <= OPEN_BUS;
                        timeout_reg <= 1'b1;
                        ready_reg   <= 1'b1;
                        state_reg   <= ST_DONE;
                    end else begin
                        to_cnt_reg <= to_cnt_inc;
                    end
                end

                ST_HOLD: begin
                    // With MIN_WAIT=0 this state still costs one cycle, giving
                    // READY one edge after completion.
                    if (wait_cnt_reg == 4'(MIN_WAIT)) begin
                        ready_reg <= 1'b1;
                        state_reg <= ST_DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 4'd1;
                    end
                end

                ST_DONE: begin
                    if (bus.RD_n && bus.WR_n && bus.INTA_n) begin
                        req_inta_reg <= 1'b0;
                        state_reg    <= ST_IDLE;
                    end
                end

                default: begin
                    ready_reg <= 1'b1;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.din       = din_reg;
    assign bus.READY     = ready_reg;
    assign bus.req_valid = req_valid_reg;
    assign bus.req_write = req_write_reg;
    assign bus.req_io    = req_io_reg;
    assign bus.req_inta  = req_inta_reg;
    assign bus.req_addr  = req_addr_reg;
    assign bus.req_wdata = req_wdata_reg;
    assign bus.timeout   = timeout_reg;

endmodule
